caesar_decoder: RTL and testbench
=================================

Name: caesar_decoder

Overview:
Receive-side counterpart of the Caesar digit encoder. Accepts 5-bit shifted codes and subtracts a runtime-loadable key modulo 32 to recover BCD digits 0-9. Flags out-of-range results as errors. Results are buffered in a small FIFO behind valid/ready handshakes, so the display stage can stall without losing codes.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
KEY_DEFAULT, 3, key value loaded on reset (0..31)
ERRW, 8, width of the saturating error counter

Ports:
ready  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
key_load  in  1  load key_in into the key register this cycle
key_in  in  5  new key value
in_valid  in  1  code_in is valid
in_ready  out  1  block can accept a code
code_in  in  5  encoded symbol, S4..S0 order (bit 4 = MSB)
out_valid  out  1  FIFO head is valid
out_ready  in  1  consumer takes the head this cycle
digit_out  out  4  decoded digit; 4'hF when out_err=1
out_err  out  1  head entry was out of range
err_count  out  ERRW  count of rejected codes, saturating at all-ones

Behaviour:
- Decode, combinational at the input: diff = (code_in - key) mod 32, 5-bit wrap. The entry is valid iff diff <= 9.
  - Valid: push {err=0, digit=diff[3:0]}.
  - Invalid: push {err=1, digit=4'hF}.
- Accept: in_valid && in_ready at a rising edge.
- Pop: out_valid && out_ready at a rising edge.
- Occupancy FSM, derived from count (0..DEPTH):
  - EMPTY: count=0. PARTIAL: 0<count<DEPTH. FULL: count=DEPTH.
  - Push only: count+1. Pop only: count-1. Push and pop together: count unchanged, both pointers advance.
- in_ready = (count != DEPTH), registered-state based.
  - When FULL, in_ready is low even if out_ready is high the same cycle; there is no pass-through.
- out_valid = (count != 0). digit_out and out_err are driven from the head entry.
  - They hold stable while out_valid=1 and out_ready=0.
- Latency: a code accepted at edge N is visible at the outputs after edge N when the FIFO was EMPTY.
  - Otherwise it is visible after all earlier entries are popped.
  - Order is strictly FIFO.
- Pointers: rd_ptr and wr_ptr are log2(DEPTH) bits and wrap naturally.
- Key register:
  - key_load=1 sets key <= key_in at the edge.
  - A code accepted in the same cycle as key_load decodes with the OLD key.
  - The new key applies from the next cycle.
  - key_load is honoured regardless of FIFO state.
- err_count increments on each accepted invalid code and saturates; it is never decremented.
- in_valid while in_ready=0: no state change. The producer must hold code_in.
- Reset (sync, any cycle, including mid-transfer or while FULL), at the next edge:
  - count=0 and pointers=0, so out_valid=0 and in_ready=1.
  - key=KEY_DEFAULT, err_count=0.
  - digit_out=4'h0, out_err=0 (head mux forced to zero while EMPTY).
  - A push or pop presented in the reset cycle is discarded.
- FIFO storage contents need no reset. Outputs never expose stale data when out_valid=0; they read 0.

Decomposition:
- Shared package caesar_pkg:
  - CODE_W=5, DIGIT_W=4, MAX_DIGIT=9, ERR_DIGIT=4'hF.
  - Entry typedef {err, digit}.
  - Default key constant, shared with the encoder so both ends agree.
- One sub-module, caesar_unshift: purely combinational (code, key) -> (digit, err). It is reusable by a future checker on the encoder side.
- The FIFO, key register and counter stay in the top.

Test Plan:
- Default key 3, out_ready=1. Send codes 3, 7, 12 -> digits 0, 4, 9 in order, out_err=0, err_count=0. Each appears one edge after its accept.
- Key 3, send codes 13 and 2 -> two entries with out_err=1, digit_out=4'hF; err_count=2.
- key_load with key_in=30, then code 1 -> (1-30) mod 32 = 3, digit 3. Same-cycle key_load=1 (key_in=5) with code 8 accepted -> decodes with old key 3 = 5.
- DEPTH=4, out_ready=0, push codes 3,4,5,6 -> in_ready low after 4th accept. 5th code (7) held off. Then out_ready=1 -> pops 0,1,2,3, and 7 is accepted only after the first pop -> 4.
- FIFO with 2 entries, simultaneous push of code 9 and pop -> count stays 2, order preserved (next heads 1 then 6).
- Assert reset while FULL with err_count=5 and key=30 -> next cycle out_valid=0, in_ready=1, digit_out=0, err_count=0. Then code 3 decodes to 0, confirming the key is back to 3.

Source files
------------

// File: rtl/caesar_pkg.sv
// caesar_pkg: shared constants, entry type and occupancy states for the Caesar digit codec
package caesar_pkg;
   localparam int CODE_W = 5;
   localparam int DIGIT_W = 4;
   localparam int MAX_DIGIT = 9;
   localparam logic [DIGIT_W-1:0] ERR_DIGIT = 4'hF;
   localparam int DEFAULT_KEY = 3;
   typedef struct packed {
      logic err;
      logic [DIGIT_W-1:0] digit;
   } entry_t;
   typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_t;
endpackage

// File: rtl/caesar_unshift.sv
// caesar_unshift: combinational (code - key) mod 32 with range check against BCD digits
module caesar_unshift
   import caesar_pkg::*;
(
   input  logic [CODE_W-1:0]  code,
   input  logic [CODE_W-1:0]  key,
   output logic [DIGIT_W-1:0] digit,
   output logic               err
);
   logic [CODE_W-1:0] diff;
   assign diff = code - key;
   assign err = diff > CODE_W'(MAX_DIGIT);
   assign digit = err ? ERR_DIGIT : diff[DIGIT_W-1:0];
endmodule

// File: rtl/caesar_decoder.sv
// caesar_decoder: unshifts codes with a loadable key and queues results in a FIFO
module caesar_decoder
   import caesar_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int KEY_DEFAULT = DEFAULT_KEY,
   parameter int ERRW = 8
) (
   input  logic               ready,
   input  logic               reset,
   input  logic               key_load,
   input  logic [CODE_W-1:0]  key_in,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [CODE_W-1:0]  code_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DIGIT_W-1:0] digit_out,
   output logic               out_err,
   output logic [ERRW-1:0]    err_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   entry_t mem [DEPTH];
   entry_t entry, head;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count, count_nxt;
   logic [CODE_W-1:0] key;
   occ_t state, state_nxt;
   logic push, pop;
   caesar_unshift u_unshift (
      .code  (code_in),
      .key   (key),
      .digit (entry.digit),
      .err   (entry.err)
   );
   assign in_ready = state != FULL;
   assign out_valid = state != EMPTY;
   assign push = in_valid && in_ready;
   assign pop = out_valid && out_ready;
   assign head = mem[rd_ptr];
   assign digit_out = out_valid ? head.digit : '0;
   assign out_err = out_valid && head.err;
   // next occupancy: count moves only when exactly one of push/pop happens
   always_comb begin
      count_nxt = (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
      state_nxt = (count_nxt == '0) ? EMPTY : (count_nxt == CW'(DEPTH)) ? FULL : PARTIAL;
   end
   // occupancy state, pointers, key and error counter
   always_ff @(posedge ready) begin
      if (reset) begin
         state <= EMPTY;
         count <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         key <= CODE_W'(KEY_DEFAULT);
         err_count <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (key_load) key <= key_in;
         if (push && entry.err && err_count != '1) err_count <= err_count + 1'b1;
      end
   end
   // storage needs no reset; the write pointer reset makes old contents unreachable
   always_ff @(posedge ready) begin
      if (push && !reset) mem[wr_ptr] <= entry;
   end
endmodule

// File: tb/tb_caesar_decoder.sv
// tb_caesar_decoder: directed vectors with hand-computed digits for caesar_decoder
module tb_caesar_decoder;
   logic clk = 0, rst = 1;
   logic key_load = 0, in_valid = 0, out_ready = 0;
   logic [4:0] key_in = 0, code_in = 0;
   logic in_ready, out_valid, out_err;
   logic [3:0] digit_out;
   logic [7:0] err_count;
   int checks = 0, failures = 0;

   caesar_decoder #(.DEPTH(4), .KEY_DEFAULT(3), .ERRW(8)) dut (
      .ready     (clk),
      .reset     (rst),
      .key_load  (key_load),
      .key_in    (key_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .code_in   (code_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .digit_out (digit_out),
      .out_err   (out_err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic head(input string tag, input logic [3:0] d, input logic e);
      check({tag, "_valid"}, 32'(out_valid), 1);
      check({tag, "_digit"}, 32'(digit_out), 32'(d));
      check({tag, "_err"}, 32'(out_err), 32'(e));
   endtask

   initial begin
      tick();
      tick();
      check("rst_valid", 32'(out_valid), 0);
      check("rst_ready", 32'(in_ready), 1);
      check("rst_digit", 32'(digit_out), 0);
      check("rst_err", 32'(out_err), 0);
      check("rst_errcnt", 32'(err_count), 0);
      rst = 0;
      // codes 3,7,12 with key 3 -> 0,4,9, each visible right after its accept
      out_ready = 1;
      in_valid = 1;
      code_in = 3; tick(); head("t1a", 0, 0);
      code_in = 7; tick(); head("t1b", 4, 0);
      code_in = 12; tick(); head("t1c", 9, 0);
      in_valid = 0; tick();
      check("t1_empty", 32'(out_valid), 0);
      check("t1_errcnt", 32'(err_count), 0);
      // out of range: 13-3=10, 2-3=31
      in_valid = 1;
      code_in = 13; tick(); head("t2a", 4'hF, 1);
      code_in = 2; tick(); head("t2b", 4'hF, 1);
      in_valid = 0; tick();
      check("t2_errcnt", 32'(err_count), 2);
      check("t2_empty_digit", 32'(digit_out), 0);
      // key 30: (1-30) mod 32 = 3
      key_load = 1; key_in = 30; tick();
      key_load = 0; in_valid = 1; code_in = 1; tick(); head("t3a", 3, 0);
      in_valid = 0; key_load = 1; key_in = 3; tick();
      // same-cycle load decodes with the old key: 8-3=5
      key_load = 1; key_in = 5; in_valid = 1; code_in = 8; tick(); head("t3b", 5, 0);
      key_load = 0; code_in = 8; tick(); head("t3c", 3, 0);
      in_valid = 0; key_load = 1; key_in = 3; tick();
      key_load = 0;
      check("t3_empty", 32'(out_valid), 0);
      // fill to DEPTH with out_ready low
      out_ready = 0; in_valid = 1;
      code_in = 3; tick();
      code_in = 4; tick();
      code_in = 5; tick();
      check("t4_ready3", 32'(in_ready), 1);
      code_in = 6; tick();
      check("t4_full", 32'(in_ready), 0);
      code_in = 7; tick();
      check("t4_held", 32'(in_ready), 0);
      head("t4_h0", 0, 0);
      out_ready = 1; tick(); head("t4_h1", 1, 0);
      check("t4_ready_after_pop", 32'(in_ready), 1);
      tick(); head("t4_h2", 2, 0);
      in_valid = 0;
      tick(); head("t4_h3", 3, 0);
      tick(); head("t4_h4", 4, 0);
      tick();
      check("t4_empty", 32'(out_valid), 0);
      // two entries {0,1}, then push 9 (->6) while popping
      out_ready = 0; in_valid = 1;
      code_in = 3; tick();
      code_in = 4; tick();
      out_ready = 1; code_in = 9; tick(); head("t5a", 1, 0);
      check("t5_ready", 32'(in_ready), 1);
      in_valid = 0; tick(); head("t5b", 6, 0);
      tick();
      check("t5_empty", 32'(out_valid), 0);
      // fill with key 30: three invalid (20) and one valid (1 -> 3)
      out_ready = 0; key_load = 1; key_in = 30; tick();
      key_load = 0; in_valid = 1;
      code_in = 20; tick(); head("t6_h", 4'hF, 1);
      tick();
      tick();
      code_in = 1; tick();
      check("t6_full", 32'(in_ready), 0);
      check("t6_errcnt", 32'(err_count), 5);
      rst = 1; out_ready = 1; code_in = 5; tick();
      check("t6_rst_valid", 32'(out_valid), 0);
      check("t6_rst_ready", 32'(in_ready), 1);
      check("t6_rst_digit", 32'(digit_out), 0);
      check("t6_rst_err", 32'(out_err), 0);
      check("t6_rst_errcnt", 32'(err_count), 0);
      rst = 0; code_in = 3; tick(); head("t6_key", 0, 0);
      in_valid = 0; tick();
      check("t6_end", 32'(out_valid), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
